// File: rtl/kan_layer_sequencer.sv
// ---------------------------------------------------------------------------
// kan_layer_sequencer
//
// Kernel-side sequencer for the ping-pong layer buffer. It accepts one layer
// descriptor at a time and announces the layer to the buffer. It caches the
// layer's input vector and performs signed fixed-point MACs against the
// streamed weight array. It then writes one saturated result per output
// neuron back into the buffer.
//
// Optional feature (macro KAN_SEQ_RELU_EN): when defined, negative results of
// non-last layers are clamped to zero (ReLU). Last-layer results pass through
// unmodified. When undefined, results are always the saturated value.
//
// Ports:
//   aclk, aresetn              clock, asynchronous active-high reset
//   cfg_valid/cfg_ready        layer descriptor handshake
//   cfg_nin/cfg_nout/cfg_last  descriptor fields
//   cfg_err                    one-cycle pulse when a descriptor is rejected
//   c_new/c_lfirst/c_llast     layer-start pulse and qualifiers to the buffer
//   k_rvalid/k_rready/k_rdata  activation read stream from the buffer
//   w_tvalid/w_tready/w_tdata  weight stream from the DMA
//   k_wvalid/k_wready/k_wdata  result write stream to the buffer
//   busy                       high whenever the FSM is outside IDLE
//   done                       one-cycle pulse after the final layer completes
// ---------------------------------------------------------------------------
module kan_layer_sequencer #(
    parameter int DWIDTH  = 16,
    parameter int FRAC    = 8,
    parameter int ACCW    = 40,
    parameter int MAX_DIM = 64
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [$clog2(MAX_DIM+1)-1:0]   cfg_nin,
    input  logic [$clog2(MAX_DIM+1)-1:0]   cfg_nout,
    input  logic                           cfg_last,
    output logic                           cfg_err,
    output logic                           c_new,
    output logic                           c_lfirst,
    output logic                           c_llast,
    input  logic                           k_rvalid,
    output logic                           k_rready,
    input  logic [DWIDTH-1:0]              k_rdata,
    input  logic                           w_tvalid,
    output logic                           w_tready,
    input  logic [DWIDTH-1:0]              w_tdata,
    output logic                           k_wvalid,
    input  logic                           k_wready,
    output logic [DWIDTH-1:0]              k_wdata,
    output logic                           busy,
    output logic                           done
);

    localparam int CW = $clog2(MAX_DIM + 1);
    localparam int IW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int PW = 2 * DWIDTH;

    // Saturation bounds expressed at accumulator width; the minimum is the
    // bitwise complement of the maximum in two's complement.
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (DWIDTH - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEWL,
        S_LOAD,
        S_MAC,
        S_WRITE,
        S_NEXT
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            nin_q;
    logic [CW-1:0]            nout_q;
    logic [CW-1:0]            i_q;
    logic [CW-1:0]            j_q;
    logic                     last_q;
    logic                     first_q;
    logic signed [ACCW-1:0]   acc_q;
    logic signed [DWIDTH-1:0] cache_q [MAX_DIM];

    logic signed [ACCW-1:0]   acc_d;
    logic signed [PW-1:0]     prod;
    logic signed [ACCW-1:0]   shifted;
    logic [DWIDTH-1:0]        result_d;
    logic [IW-1:0]            i_idx;
    logic                     cfg_legal;
    logic                     cfg_fire;
    logic                     rd_fire;
    logic                     w_fire;
    logic                     wr_fire;
    logic                     i_last;
    logic                     j_last;

    assign i_idx     = i_q[IW-1:0];
    assign cfg_legal = (cfg_nin != '0) && (cfg_nout != '0) &&
                       (cfg_nin <= CW'(MAX_DIM)) && (cfg_nout <= CW'(MAX_DIM));
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign rd_fire   = k_rvalid & k_rready;
    assign w_fire    = w_tvalid & w_tready;
    assign wr_fire   = k_wvalid & k_wready;
    assign i_last    = (i_q == nin_q - CW'(1));
    assign j_last    = (j_q == nout_q - CW'(1));

    // The MAC datapath computes the accumulator including the current weight.
    // On the final weight of a neuron, the formatted result is captured from
    // acc_d directly, so k_wvalid can rise on the very next cycle.
    assign prod    = PW'(cache_q[i_idx]) * PW'($signed(w_tdata));
    assign acc_d   = acc_q + ACCW'(prod);
    assign shifted = acc_d >>> FRAC;

    always_comb begin
        result_d = shifted[DWIDTH-1:0];
        if (shifted > SAT_MAX) begin
            result_d = SAT_MAX[DWIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result_d = SAT_MIN[DWIDTH-1:0];
        end
`ifdef KAN_SEQ_RELU_EN
        if (!last_q && result_d[DWIDTH-1]) begin
            result_d = '0;
        end
`endif
    end

    // The input-vector cache has no reset; entries are always written during
    // LOAD before MAC reads them.
    always_ff @(posedge aclk) begin
        if (rd_fire) begin
            cache_q[i_idx] <= k_rdata;
        end
    end

    // Main FSM. Every handshake output is a register that is set on entry to
    // its state, so at most one of k_rready, w_tready and k_wvalid is ever
    // high.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state_q   <= S_IDLE;
            nin_q     <= '0;
            nout_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            acc_q     <= '0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            c_new     <= 1'b0;
            c_lfirst  <= 1'b0;
            c_llast   <= 1'b0;
            k_rready  <= 1'b0;
            w_tready  <= 1'b0;
            k_wvalid  <= 1'b0;
            k_wdata   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cfg_err  <= 1'b0;
            c_new    <= 1'b0;
            c_lfirst <= 1'b0;
            c_llast  <= 1'b0;
            done     <= 1'b0;

            case (state_q)
                S_IDLE, S_NEXT: begin
                    if (state_q == S_NEXT && last_q) begin
                        first_q   <= 1'b1;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (cfg_fire) begin
                        // Rejected descriptors are consumed but leave the
                        // state untouched.
                        if (cfg_legal) begin
                            nin_q     <= cfg_nin;
                            nout_q    <= cfg_nout;
                            last_q    <= cfg_last;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                            c_new     <= 1'b1;
                            c_lfirst  <= first_q;
                            c_llast   <= cfg_last;
                            state_q   <= S_NEWL;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end

                S_NEWL: begin
                    first_q  <= 1'b0;
                    i_q      <= '0;
                    k_rready <= 1'b1;
                    state_q  <= S_LOAD;
                end

                S_LOAD: begin
                    if (rd_fire) begin
                        i_q <= i_q + CW'(1);
                        if (i_last) begin
                            i_q      <= '0;
                            j_q      <= '0;
                            acc_q    <= '0;
                            k_rready <= 1'b0;
                            w_tready <= 1'b1;
                            state_q  <= S_MAC;
                        end
                    end
                end

                S_MAC: begin
                    if (w_fire) begin
                        acc_q <= acc_d;
                        i_q   <= i_q + CW'(1);
                        if (i_last) begin
                            w_tready <= 1'b0;
                            k_wvalid <= 1'b1;
                            k_wdata  <= result_d;
                            state_q  <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (wr_fire) begin
                        k_wvalid <= 1'b0;
                        if (j_last) begin
                            // A non-last layer waits in NEXT for its successor.
                            done      <= last_q;
                            cfg_ready <= ~last_q;
                            state_q   <= S_NEXT;
                        end else begin
                            j_q      <= j_q + CW'(1);
                            i_q      <= '0;
                            acc_q    <= '0;
                            w_tready <= 1'b1;
                            state_q  <= S_MAC;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
